// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed operands
// handled as magnitudes with a final sign-correction step.
//
// state | meaning
// IDLE  | waiting for START; divide-by-zero answered here in one cycle
// CALC  | WIDTH shift/trial-subtract steps on the magnitudes
// FIX   | apply operand signs, publish results, pulse DONE
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] restored;
    logic [WIDTH:0]   diff;

    // quo doubles as the dividend shift register: MSB out, quotient bit in
    always_comb begin
        mag_a    = (SIGNED && DIVIDEND[WIDTH-1]) ? -DIVIDEND : DIVIDEND;
        mag_b    = (SIGNED && DIVISOR[WIDTH-1])  ? -DIVISOR  : DIVISOR;
        restored = {rem[WIDTH-2:0], quo[WIDTH-1]};
        diff     = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        if (DIVISOR == '0) begin
                            QUOTIENT    <= '1;
                            REMAINDER   <= DIVIDEND;
                            DIV_BY_ZERO <= 1'b1;
                            DONE        <= 1'b1;
                        end else begin
                            neg_quo <= SIGNED & (DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1]);
                            neg_rem <= SIGNED & DIVIDEND[WIDTH-1];
                            quo     <= mag_a;
                            dvs     <= mag_b;
                            rem     <= '0;
                            count   <= '0;
                            BUSY    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!diff[WIDTH]) begin
                        rem <= diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= restored;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    QUOTIENT    <= neg_quo ? -quo : quo;
                    REMAINDER   <= neg_rem ? -rem : rem;
                    DIV_BY_ZERO <= 1'b0;
                    DONE        <= 1'b1;
                    BUSY        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed and randomized checks of iter_divider against an arithmetic
// reference model (native SV division on 64-bit values).
module tb_iter_divider;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic         SIGNED = 1'b0;
    logic [W-1:0] DIVIDEND = '0;
    logic [W-1:0] DIVISOR = '0;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] QUOTIENT;
    logic [W-1:0] REMAINDER;
    logic         DIV_BY_ZERO;

    int n_assert = 0;
    int n_fail   = 0;

    iter_divider #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .SIGNED     (SIGNED),
        .DIVIDEND   (DIVIDEND),
        .DIVISOR    (DIVISOR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .QUOTIENT   (QUOTIENT),
        .REMAINDER  (REMAINDER),
        .DIV_BY_ZERO(DIV_BY_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder carries the dividend's sign.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        longint sa;
        longint sb;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Called just after a falling edge; returns at the falling edge where DONE is seen.
    // poke_at >= 0 raises a second START (5/5) in that cycle of the operation.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke_at);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           cycles;
        int           busy_cycles;
        model(s, a, b, eq, er, edz);
        START    = 1'b1;
        SIGNED   = s;
        DIVIDEND = a;
        DIVISOR  = b;
        @(negedge CLK);
        START    = 1'b0;
        SIGNED   = 1'($urandom);
        DIVIDEND = $urandom;
        DIVISOR  = $urandom;
        cycles      = 0;
        busy_cycles = 0;
        while (DONE !== 1'b1 && cycles < 100) begin
            if (BUSY === 1'b1) busy_cycles++;
            if (cycles == poke_at) begin
                START    = 1'b1;
                SIGNED   = 1'b0;
                DIVIDEND = 5;
                DIVISOR  = 5;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            cycles++;
        end
        START = 1'b0;
        check({tag, "_latency"}, W'(cycles), (b == 0) ? 32'd0 : 32'd33);
        check({tag, "_busy_cycles"}, W'(busy_cycles), (b == 0) ? 32'd0 : 32'd33);
        check({tag, "_busy_at_done"}, W'(BUSY), 32'd0);
        check({tag, "_quotient"}, QUOTIENT, eq);
        check({tag, "_remainder"}, REMAINDER, er);
        check({tag, "_div_by_zero"}, W'(DIV_BY_ZERO), W'(edz));
    endtask

    task automatic pulse_check(input string tag);
        @(negedge CLK);
        check({tag, "_done_pulse"}, W'(DONE), 32'd0);
    endtask

    task automatic no_done_window(input string tag, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        check({tag, "_no_extra_done"}, W'(dones), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge CLK);
        check("rst_busy", W'(BUSY), 32'd0);
        check("rst_done", W'(DONE), 32'd0);
        check("rst_quotient", QUOTIENT, 32'd0);
        check("rst_remainder", REMAINDER, 32'd0);
        check("rst_dbz", W'(DIV_BY_ZERO), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        run_op("u241_177", 1'b0, 32'd241, 32'd177, -1);
        pulse_check("u241_177");
        run_op("u_big", 1'b0, 32'hF0F0_F002, 32'h4000_00F1, -1);
        pulse_check("u_big");
        run_op("s_m7_2", 1'b1, -32'sd7, 32'd2, -1);
        pulse_check("s_m7_2");
        run_op("s_7_m2", 1'b1, 32'd7, -32'sd2, -1);
        pulse_check("s_7_m2");
        run_op("s_m7_m2", 1'b1, -32'sd7, -32'sd2, -1);
        pulse_check("s_m7_m2");
        run_op("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        pulse_check("s_overflow");
        run_op("dbz_418", 1'b0, 32'd418, 32'd0, -1);
        pulse_check("dbz_418");
        run_op("after_dbz", 1'b0, 32'd10, 32'd3, -1);
        pulse_check("after_dbz");

        run_op("busy_ignore", 1'b0, 32'd100, 32'd7, 10);
        no_done_window("busy_ignore", 40);

        START    = 1'b1;
        SIGNED   = 1'b0;
        DIVIDEND = 32'd123456;
        DIVISOR  = 32'd789;
        @(negedge CLK);
        START = 1'b0;
        repeat (20) @(negedge CLK);
        check("midrst_busy_before", W'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("midrst_busy", W'(BUSY), 32'd0);
        check("midrst_done", W'(DONE), 32'd0);
        check("midrst_quotient", QUOTIENT, 32'd0);
        check("midrst_remainder", REMAINDER, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        no_done_window("midrst", 40);

        run_op("b2b_first", 1'b1, 32'd1000, -32'sd9, -1);
        run_op("b2b_second", 1'b0, 32'hDEAD_BEEF, 32'd1234, -1);
        pulse_check("b2b_second");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 3));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), 1'($urandom), ra, rb, -1);
            pulse_check($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
